mem_port_arbiter: RTL

//  Shares the single-port synchronous data memory between the CPU (port C) and one I/O peripheral master (port P).

---
 rtl/arb_pkg.sv | 18 +
 rtl/arb_fair_counter.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_e   - arbiter FSM states
//   *_MEM/...     - data-memory map; the peripheral may only write at or
//                   above IO_MEM.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_C = 2'd1,
    SERVE_P = 2'd2
  } arb_state_e;

  localparam logic [15:0] INSTRUCTION_MEM   = 16'h0000;
  localparam logic [15:0] INTERRUPT_CONTROL = 16'h4000;
  localparam logic [15:0] DATA_STACK        = 16'h6000;
  localparam logic [15:0] IO_MEM            = 16'hCFFD;

endpackage

// File: rtl/arb_fair_counter.sv
// arb_fair_counter: CPU-priority decision with a saturating burst counter
// that bounds how long the peripheral can be starved.
//   clk, reset        clock, synchronous active-high reset
//   c_req_i, p_req_i  raw requests
//   c_gnt_i, p_gnt_i  grants currently on the bus (that port sits out)
//   c_win_o, p_win_o  winner of the decision registered at the next edge
module arb_fair_counter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_CPU_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic c_req_i,
  input  logic p_req_i,
  input  logic c_gnt_i,
  input  logic p_gnt_i,
  output logic c_win_o,
  output logic p_win_o
);

  localparam int unsigned     CNT_W   = $clog2(MAX_CPU_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CPU_BURST);

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  // The CPU's raw request (not the gnt-masked one) decides whether P may
  // pre-empt: while C is being served and still holding req, P waits unless
  // the burst budget is used up. This yields the C,C,C,C,P pattern under
  // continuous contention.
  always_comb begin
    p_win_o     = p_req_i && !p_gnt_i && (!c_req_i || burst_cnt_q == CNT_MAX);
    c_win_o     = !p_win_o && c_req_i && !c_gnt_i;
    burst_cnt_d = burst_cnt_q;
    if (p_win_o || !p_req_i) begin
      burst_cnt_d = '0;
    end else if (c_win_o && burst_cnt_q != CNT_MAX) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port synchronous data memory between
// the CPU (port C) and one peripheral master (port P).
//   c_req/c_we/c_adr/c_wdata  CPU request, held until c_gnt
//   c_gnt, c_rvalid, c_rdata  CPU grant pulse, read-data valid pulse, data
//   p_*                       same for the peripheral
//   p_err                     P write below IO_BASE was suppressed
//   mem_adr/mem_wdata/mem_we  memory bus; mem_rdata valid one cycle later
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned       WIDTH         = 16,
  parameter int unsigned       ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] IO_BASE       = ADDR_W'(IO_MEM),
  parameter int unsigned       MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_adr,
  input  logic [WIDTH-1:0]  c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [WIDTH-1:0]  c_rdata,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_adr,
  input  logic [WIDTH-1:0]  p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [WIDTH-1:0]  p_rdata,
  output logic              p_err,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_we,
  input  logic [WIDTH-1:0]  mem_rdata
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              p_err_q, p_err_d;
  logic              acc_rd_q, acc_rd_d;
  logic              c_rvalid_q, c_rvalid_d;
  logic              p_rvalid_q, p_rvalid_d;
  logic              c_win, p_win;

  assign c_gnt = (state_q == SERVE_C);
  assign p_gnt = (state_q == SERVE_P);

  arb_fair_counter #(
    .MAX_CPU_BURST(MAX_CPU_BURST)
  ) u_fair (
    .clk     (clk),
    .reset   (reset),
    .c_req_i (c_req),
    .p_req_i (p_req),
    .c_gnt_i (c_gnt),
    .p_gnt_i (p_gnt),
    .c_win_o (c_win),
    .p_win_o (p_win)
  );

  always_comb begin
    state_d     = IDLE;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    p_err_d     = 1'b0;
    acc_rd_d    = 1'b0;
    c_rvalid_d  = (state_q == SERVE_C) && acc_rd_q;
    p_rvalid_d  = (state_q == SERVE_P) && acc_rd_q;
    if (p_win) begin
      state_d     = SERVE_P;
      mem_adr_d   = p_adr;
      mem_wdata_d = p_wdata;
      mem_we_d    = p_we && (p_adr >= IO_BASE);
      p_err_d     = p_we && (p_adr < IO_BASE);
      acc_rd_d    = !p_we;
    end else if (c_win) begin
      state_d     = SERVE_C;
      mem_adr_d   = c_adr;
      mem_wdata_d = c_wdata;
      mem_we_d    = c_we;
      acc_rd_d    = !c_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      p_err_q     <= 1'b0;
      acc_rd_q    <= 1'b0;
      c_rvalid_q  <= 1'b0;
      p_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      p_err_q     <= p_err_d;
      acc_rd_q    <= acc_rd_d;
      c_rvalid_q  <= c_rvalid_d;
      p_rvalid_q  <= p_rvalid_d;
    end
  end

  // Write strobe is masked by reset so an access interrupted by reset never
  // reaches the memory, even in the cycle reset is first seen.
  assign mem_we    = mem_we_q && !reset;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign p_err     = p_err_q;
  assign c_rvalid  = c_rvalid_q;
  assign p_rvalid  = p_rvalid_q;
  assign c_rdata   = mem_rdata;
  assign p_rdata   = mem_rdata;

endmodule
